// File: rtl/pmod_pwm_dac.sv
// pmod_pwm_dac: multi-channel PWM / sigma-delta 1-bit audio DAC with a one-slot sample buffer
module pmod_pwm_dac #(
  parameter int WIDTH = 16,
  parameter int CH    = 2,
  parameter int RES   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                mode,
  input  logic [CH*WIDTH-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic [CH-1:0]       pwm_out,
  output logic                period_start
);
  localparam logic [RES-1:0] MID = {1'b1, {(RES-1){1'b0}}};
  logic [RES-1:0] cnt_q, cnt_d;
  logic pend_full_q, pend_full_d, act_mode_q, act_mode_d, start_d, last, accept;
  logic [CH-1:0][RES-1:0] duty, pend_q, pend_d, act_q, act_d, acc_q, acc_d;
  logic [CH-1:0] pwm_d;
  logic [RES:0] sum;
  for (genvar c = 0; c < CH; c++) begin : g_duty
    logic [WIDTH-1:0] ob;
    assign ob = {~sample_in[c*WIDTH+WIDTH-1], sample_in[c*WIDTH +: WIDTH-1]};
    assign duty[c] = RES'(ob >> (WIDTH-RES));
  end
  assign sample_ready = ~rst & ~pend_full_q;
  // next-state: period counter, buffer hand-off at the boundary, per-channel modulators
  always_comb begin
    last = enable && (cnt_q == '1);
    accept = sample_valid & sample_ready;
    cnt_d = enable ? cnt_q + 1'b1 : '0;
    pend_d = accept ? duty : pend_q;
    pend_full_d = last ? accept : (pend_full_q | accept);
    act_d = (last && pend_full_q) ? pend_q : act_q;
    act_mode_d = last ? mode : act_mode_q;
    start_d = enable && (cnt_q == '0);
    sum = '0;
    pwm_d = '0;
    acc_d = acc_q;
    for (int c = 0; c < CH; c++) begin
      sum = {1'b0, acc_q[c]} + {1'b0, act_q[c]};
      pwm_d[c] = enable & (act_mode_q ? sum[RES] : (cnt_q < act_q[c]));
      acc_d[c] = (!enable || (last && mode != act_mode_q)) ? '0 : act_mode_q ? sum[RES-1:0] : acc_q[c];
    end
  end
  // state registers with synchronous reset to midscale, PWM mode, empty slot
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pend_full_q <= 1'b0;
      pend_q <= '0;
      act_q <= {CH{MID}};
      act_mode_q <= 1'b0;
      acc_q <= '0;
      pwm_out <= '0;
      period_start <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_q <= pend_d;
      act_q <= act_d;
      act_mode_q <= act_mode_d;
      acc_q <= acc_d;
      pwm_out <= pwm_d;
      period_start <= start_d;
    end
  end
endmodule

// File: tb/tb_pmod_pwm_dac.sv
// tb_pmod_pwm_dac: randomized scoreboard bench counting ones per output period
module tb_pmod_pwm_dac;
  localparam int WIDTH = 16, CH = 2, RES = 8, P = 1 << RES;
  typedef logic [CH-1:0][RES:0] duty_t;
  typedef struct packed { logic m; duty_t d; } exp_t;
  typedef struct packed { int per; duty_t d; } app_t;
  logic clk = 0, rst = 1, enable = 0, mode = 0, sample_valid = 0;
  logic [CH*WIDTH-1:0] sample_in = '0;
  logic sample_ready, period_start;
  logic [CH-1:0] pwm_out;
  int tests = 0, fails = 0;
  exp_t exp_q[$];
  app_t app_q[$];
  logic [CH*WIDTH-1:0] src_q[$];
  duty_t cur_d, mid_d;
  logic mode_app = 0;
  int k = 0, pos = 0;
  bit mon_on = 0, resync = 1, acc_flag = 0;
  int wpos = -1;
  int ones[CH];
  bit rise[CH], seen0[CH];
  exp_t e;

  pmod_pwm_dac #(.WIDTH(WIDTH), .CH(CH), .RES(RES)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  function automatic duty_t conv(input logic [CH*WIDTH-1:0] s);
    duty_t r;
    for (int c = 0; c < CH; c++)
      r[c] = (RES+1)'((int'($signed(s[c*WIDTH +: WIDTH])) + (1 << (WIDTH-1))) / (1 << (WIDTH-RES)));
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // monitor: one window per period, compared against the queued expectation at its end
  always @(negedge clk) begin
    if (!mon_on) begin
      wpos = -1;
      exp_q.delete();
    end else begin
      if (period_start) begin
        if (wpos >= 0) check("window_len", wpos, P);
        wpos = 0;
        for (int c = 0; c < CH; c++) begin ones[c] = 0; rise[c] = 0; seen0[c] = 0; end
      end
      if (wpos >= 0) begin
        for (int c = 0; c < CH; c++)
          if (pwm_out[c]) begin ones[c]++; if (seen0[c]) rise[c] = 1; end
          else seen0[c] = 1;
        wpos++;
        if (wpos == P) begin
          wpos = -1;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_empty: window finished with no expectation queued");
          end else begin
            e = exp_q.pop_front();
            for (int c = 0; c < CH; c++) begin
              check($sformatf("ones_ch%0d", c), ones[c], int'(e.d[c]));
              if (!e.m) check($sformatf("pwm_prefix_ch%0d", c), int'(rise[c]), 0);
            end
          end
        end
      end
    end
  end

  // one clock of stimulus: period bookkeeping, model update and valid/ready source
  task automatic tick();
    @(negedge clk);
    if (mon_on && period_start) begin
      k++;
      pos = 0;
      if (!resync) mode_app = mode;
      resync = 0;
      while (app_q.size() > 0 && app_q[0].per <= k) begin
        cur_d = app_q[0].d;
        void'(app_q.pop_front());
      end
      exp_q.push_back('{m: mode_app, d: cur_d});
    end else pos++;
    if (acc_flag) begin acc_flag = 0; void'(src_q.pop_front()); end
    sample_valid = src_q.size() > 0;
    if (sample_valid) sample_in = src_q[0];
    if (sample_valid && sample_ready) begin
      acc_flag = 1;
      app_q.push_back('{per: (pos < P-2) ? k+1 : k+2, d: conv(sample_in)});
    end
  endtask

  task automatic next_period();
    int n = 0;
    do begin tick(); n++; end while (!period_start && n < 2*P);
    if (!period_start) begin
      tests++; fails++;
      $display("FAIL period_timeout: no period_start within %0d clk", n);
    end
  endtask

  task automatic at(input int p);
    int n = 0;
    while (pos < p && n < 2*P) begin tick(); n++; end
  endtask

  task automatic period(input int p, input bit has, input logic [CH*WIDTH-1:0] s);
    if (has) begin at(p); src_q.push_back(s); end
    next_period();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1; mon_on = 0; acc_flag = 0;
    src_q.delete(); app_q.delete();
    for (int i = 0; i < cycles; i++) begin
      tick();
      check("ready_in_reset", int'(sample_ready), 0);
      check("pwm_in_reset", int'(pwm_out), 0);
      check("start_in_reset", int'(period_start), 0);
    end
    cur_d = mid_d; mode_app = 0; resync = 1;
    rst = 0; mon_on = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < CH; c++) mid_d[c] = (RES+1)'(P/2);
    cur_d = mid_d;
    do_reset(3);
    enable = 1;
    tick();
    check("ready_after_reset", int'(sample_ready), 1);
    check("first_period_start", int'(period_start), 1);
    period(0, 0, '0); period(0, 0, '0);
    period(8, 1, {16'h8000, 16'h4000}); period(0, 0, '0); period(0, 0, '0);
    period(50, 1, {16'hFFFF, 16'h7FFF}); period(0, 0, '0); period(0, 0, '0);
    at(20);
    src_q.push_back({16'hC000, 16'h2000});
    src_q.push_back({16'h1234, 16'hE000});
    src_q.push_back({16'h7FFF, 16'h8000});
    repeat (4) next_period();
    mode = 1;
    period(30, 1, {16'(($urandom)), 16'h4000}); period(0, 0, '0); period(0, 0, '0); period(0, 0, '0);
    mode = 0;
    period(253, 1, (CH*WIDTH)'($urandom)); period(0, 0, '0); period(0, 0, '0);
    period(254, 1, (CH*WIDTH)'($urandom)); period(0, 0, '0); period(0, 0, '0);
    repeat (16) begin
      if ($urandom_range(0, 3) == 0) mode = ~mode;
      period($urandom_range(0, P-1), 1'($urandom_range(0, 1)), (CH*WIDTH)'($urandom));
    end
    period(0, 0, '0); period(0, 0, '0);
    src_q.push_back((CH*WIDTH)'($urandom));
    at(99);
    check("ready_pending", int'(sample_ready), 0);
    do_reset(2);
    next_period(); period(0, 0, '0); period(0, 0, '0);
    at(77);
    enable = 0; mon_on = 0;
    repeat (50) begin
      tick();
      check("pwm_disabled", int'(pwm_out), 0);
      check("start_disabled", int'(period_start), 0);
    end
    enable = 1; mon_on = 1; resync = 1;
    tick();
    check("start_after_enable", int'(period_start), 1);
    period(0, 0, '0);
    repeat (4) begin
      if ($urandom_range(0, 1) == 0) mode = ~mode;
      period($urandom_range(0, P-1), 1, (CH*WIDTH)'($urandom));
    end
    period(0, 0, '0);
    repeat (P) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
